// File: rtl/alu_flags_stage_pkg.sv
// Shared execute-stage definitions: condition codes, flag bit positions,
// and the entry record carried from execute to writeback.
package alu_flags_stage_pkg;

  // Core datapath widths; the stage parameters must keep these defaults.
  localparam int CORE_XLEN = 32;
  localparam int CORE_RD_W = 5;

  // Bit positions inside the 4-bit {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Instruction condition codes.
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // One retired-in-order execute result as seen by writeback.
  typedef struct packed {
    logic [CORE_XLEN-1:0] result;
    logic [CORE_RD_W-1:0] rd;
    logic                 reg_we;
    logic                 branch_taken;
  } exec_entry_t;

endpackage

// File: rtl/alu_flags_stage_cond_check.sv
// Condition evaluator: decides whether an instruction's condition holds
// for a given {N,Z,C,V} flag vector. Purely combinational, shared with the
// branch unit.
module cond_check
  import alu_flags_stage_pkg::*;
(
  input  cond_e      cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition code against the individual flag bits.
  always_comb begin
    // NOTE: default assignment first so every path drives pass and no latch is inferred.
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flags_stage.sv
// Execute-stage back end. Holds the architectural flags, gates register
// write and branch on each instruction's condition, and hands a registered
// entry to writeback through a main + skid buffer so that in_ready never
// depends combinationally on out_ready.
module alu_flags_stage
  import alu_flags_stage_pkg::*;
#(
  parameter int XLEN = CORE_XLEN,  // must equal CORE_XLEN (entry layout)
  parameter int RD_W = CORE_RD_W   // must equal CORE_RD_W (entry layout)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_result,
  input  logic [3:0]      in_flags,
  input  logic [3:0]      in_cond,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_reg_we,
  input  logic            in_flag_we,
  input  logic            in_branch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_reg_we,
  output logic            out_branch_taken,
  output logic [3:0]      flags_q
);

  logic        cond_pass;
  logic        accept;
  logic        pop;
  exec_entry_t in_entry;
  exec_entry_t main_q;
  exec_entry_t skid_q;
  logic        main_valid_q;
  logic        skid_valid_q;

  // Condition is judged against the flags as they stand before this edge,
  // so an accepted flag-writer is visible to the very next instruction.
  cond_check u_cond_check (
    .cond  (cond_e'(in_cond)),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  // Handshake: the skid slot doubles as the "full" indicator, so in_ready
  // is a flop output.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign pop      = main_valid_q & out_ready;

  // Entry as it will be presented to writeback; a failed condition still
  // retires but with its side effects suppressed.
  always_comb begin
    in_entry              = '0;
    in_entry.result       = in_result;
    in_entry.rd           = in_rd;
    in_entry.reg_we       = in_reg_we & cond_pass;
    in_entry.branch_taken = in_branch & cond_pass;
  end

  // Architectural flags: only a passing, accepted flag-writer updates them;
  // flush blocks the accept and therefore the update.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (accept && cond_pass && in_flag_we) begin
      // NOTE: non-blocking assignment for all sequential state so every flop samples pre-edge values.
      flags_q <= in_flags;
    end
  end

  // Occupancy of the two buffer slots. Skid is only ever filled while main
  // is held, and drains into main on the next pop, preserving FIFO order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        main_valid_q <= accept;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_valid_q <= 1'b1;
      end else begin
        main_valid_q <= 1'b1;
      end
    end
  end

  // Buffer payloads. Main only changes on pop or when empty, which keeps
  // the outputs stable while writeback stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: payloads are cleared on reset because writeback sees zeroed outputs after reset.
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      if (pop) begin
        if (skid_valid_q) begin
          main_q <= skid_q;
        end else if (accept) begin
          main_q <= in_entry;
        end
      end else if (accept) begin
        if (main_valid_q) begin
          skid_q <= in_entry;
        end else begin
          main_q <= in_entry;
        end
      end
    end
  end

  assign out_valid        = main_valid_q;
  assign out_result       = main_q.result;
  assign out_rd           = main_q.rd;
  assign out_reg_we       = main_q.reg_we;
  assign out_branch_taken = main_q.branch_taken;

endmodule

// File: tb/tb_alu_flags_stage.sv
// Self-checking bench for alu_flags_stage: reset state, condition table,
// flag chaining, backpressure, flush, failed condition, mid-run reset and
// a randomized run against a queue-based reference model.
module tb_alu_flags_stage;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_result;
  logic [3:0]      in_flags;
  logic [3:0]      in_cond;
  logic [RD_W-1:0] in_rd;
  logic            in_reg_we;
  logic            in_flag_we;
  logic            in_branch;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [RD_W-1:0] out_rd;
  logic            out_reg_we;
  logic            out_branch_taken;
  logic [3:0]      flags_q;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_flags_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_result        (in_result),
    .in_flags         (in_flags),
    .in_cond          (in_cond),
    .in_rd            (in_rd),
    .in_reg_we        (in_reg_we),
    .in_flag_we       (in_flag_we),
    .in_branch        (in_branch),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_rd           (out_rd),
    .out_reg_we       (out_reg_we),
    .out_branch_taken (out_branch_taken),
    .flags_q          (flags_q)
  );

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp_pass;
  } cond_vec_t;

  typedef struct {
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd;
    logic            reg_we;
    logic            branch_taken;
  } exp_entry_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Condition truth written from the architectural definition of each code.
  function automatic logic ref_pass(input int code, input logic [3:0] f);
    bit n = f[3], z = f[2], c = f[1], v = f[0];
    bit r;
    case (code)
      0: r = z;              1: r = !z;
      2: r = c;              3: r = !c;
      4: r = n;              5: r = !n;
      6: r = v;              7: r = !v;
      8: r = c && !z;        9: r = !c || z;
      10: r = (n == v);      11: r = (n != v);
      12: r = !z && (n == v); 13: r = z || (n != v);
      14: r = 1;             default: r = 0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    flush      = 1'b0;
    in_result  = '0;
    in_flags   = '0;
    in_cond    = 4'hE;
    in_rd      = '0;
    in_reg_we  = 1'b0;
    in_flag_we = 1'b0;
    in_branch  = 1'b0;
  endtask

  task automatic drive(input logic [XLEN-1:0] res, input logic [3:0] fl, input logic [3:0] cond,
                       input logic [RD_W-1:0] rd, input logic rwe, input logic fwe, input logic br);
    in_valid   = 1'b1;
    in_result  = res;
    in_flags   = fl;
    in_cond    = cond;
    in_rd      = rd;
    in_reg_we  = rwe;
    in_flag_we = fwe;
    in_branch  = br;
  endtask

  // One accepted instruction; returns one cycle after the accepting edge.
  task automatic send(input logic [XLEN-1:0] res, input logic [3:0] fl, input logic [3:0] cond,
                      input logic [RD_W-1:0] rd, input logic rwe, input logic fwe, input logic br);
    drive(res, fl, cond, rd, rwe, fwe, br);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  cond_vec_t  vecs[$];
  exp_entry_t model_q[$];
  logic [3:0] model_flags;
  logic [3:0] saved_flags;
  int         got[$];

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    idle_inputs();

    vecs.push_back('{4'b1000, 4'hB, 1'b1});  // LT, N!=V
    vecs.push_back('{4'b1000, 4'hA, 1'b0});  // GE
    vecs.push_back('{4'b1000, 4'hD, 1'b1});  // LE
    vecs.push_back('{4'b1000, 4'hC, 1'b0});  // GT
    vecs.push_back('{4'b0010, 4'h8, 1'b1});  // HI
    vecs.push_back('{4'b0010, 4'h9, 1'b0});  // LS
    vecs.push_back('{4'b0110, 4'h8, 1'b0});  // HI with Z set
    vecs.push_back('{4'b0110, 4'h9, 1'b1});  // LS with Z set
    vecs.push_back('{4'b0100, 4'h0, 1'b1});  // EQ
    vecs.push_back('{4'b0100, 4'h1, 1'b0});  // NE
    vecs.push_back('{4'b1001, 4'hA, 1'b1});  // GE, N==V
    vecs.push_back('{4'b1001, 4'hC, 1'b1});  // GT
    vecs.push_back('{4'b0001, 4'h6, 1'b1});  // VS
    vecs.push_back('{4'b0001, 4'h7, 1'b0});  // VC
    vecs.push_back('{4'b1000, 4'h4, 1'b1});  // MI
    vecs.push_back('{4'b1000, 4'h5, 1'b0});  // PL
    vecs.push_back('{4'b0010, 4'h3, 1'b0});  // CC
    vecs.push_back('{4'b0000, 4'hF, 1'b0});  // NV
    vecs.push_back('{4'b0000, 4'hE, 1'b1});  // AL

    // Reset state
    do_reset();
    check("reset flags_q", flags_q, 4'b0000);
    check("reset out_valid", out_valid, 1'b0);
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_result", out_result, 0);
    check("reset out_rd", out_rd, 0);
    check("reset out_reg_we", out_reg_we, 1'b0);
    check("reset out_branch_taken", out_branch_taken, 1'b0);

    // EQ fails with Z=0, AL passes
    send(32'h5, 4'b0000, 4'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    check("eq out_valid", out_valid, 1'b1);
    check("eq out_reg_we", out_reg_we, 1'b0);
    check("eq out_result", out_result, 32'h5);
    send(32'h5, 4'b0000, 4'hE, 5'd3, 1'b1, 1'b0, 1'b0);
    check("al out_reg_we", out_reg_we, 1'b1);
    check("al out_result", out_result, 32'h5);
    check("al out_rd", out_rd, 5'd3);

    // Flag chaining: back-to-back, no bubble
    drive(32'h11, 4'b0100, 4'hE, 5'd1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(32'h22, 4'b0000, 4'h0, 5'd2, 1'b0, 1'b0, 1'b1);
    check("chain flags_q", flags_q, 4'b0100);
    check("chain in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("chain #2 result", out_result, 32'h22);
    check("chain #2 branch_taken", out_branch_taken, 1'b1);

    // Condition table: preset flags with AL, then evaluate the condition
    for (int i = 0; i < vecs.size(); i++) begin
      send(32'h100 + i, vecs[i].flags, 4'hE, 5'd0, 1'b0, 1'b1, 1'b0);
      send(32'h200 + i, 4'b1111, vecs[i].cond, 5'(i), 1'b1, 1'b0, 1'b1);
      check($sformatf("cond[%0d] flags_q", i), flags_q, vecs[i].flags);
      check($sformatf("cond[%0d] reg_we", i), out_reg_we, vecs[i].exp_pass);
      check($sformatf("cond[%0d] branch", i), out_branch_taken, vecs[i].exp_pass);
    end
    tick();

    // Backpressure: results 1..6, writeback stalled for 3 cycles
    begin
      int nxt = 1;
      got.delete();
      for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
        out_ready = (cyc >= 3);
        if (nxt <= 6) drive(32'(nxt), 4'b0000, 4'hE, 5'd0, 1'b1, 1'b0, 1'b0);
        else in_valid = 1'b0;
        if (cyc == 2) check("bp in_ready after 2", in_ready, 1'b0);
        if (cyc == 2) check("bp out_result held", out_result, 32'd1);
        if (out_valid && out_ready) got.push_back(int'(out_result));
        if (in_valid && in_ready) nxt++;
        tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp count", got.size(), 6);
      for (int i = 0; i < got.size(); i++)
        check($sformatf("bp order[%0d]", i), got[i], i + 1);
      tick();
    end

    // Flush with two buffered entries and a flag-writing instruction incoming
    saved_flags = flags_q;
    out_ready = 1'b0;
    send(32'hA1, 4'b0000, 4'hE, 5'd1, 1'b1, 1'b0, 1'b0);
    send(32'hA2, 4'b0000, 4'hE, 5'd2, 1'b1, 1'b0, 1'b0);
    check("flush pre in_ready", in_ready, 1'b0);
    in_ready_wait: begin end
    flush = 1'b1;
    drive(32'hA3, 4'b1111, 4'hE, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush out_valid", out_valid, 1'b0);
    check("flush flags_q", flags_q, saved_flags);
    check("flush in_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    // Failed NV with flag_we: flags untouched, entry still retires
    send(32'h0, 4'b0110, 4'hE, 5'd0, 1'b0, 1'b1, 1'b0);
    send(32'h77, 4'b0001, 4'hF, 5'd7, 1'b1, 1'b1, 1'b1);
    check("nv flags_q", flags_q, 4'b0110);
    check("nv out_valid", out_valid, 1'b1);
    check("nv out_result", out_result, 32'h77);
    check("nv out_reg_we", out_reg_we, 1'b0);
    check("nv out_branch", out_branch_taken, 1'b0);

    // Reset mid-operation with entries buffered, reset beats flush
    out_ready = 1'b0;
    send(32'hB1, 4'b1010, 4'hE, 5'd1, 1'b1, 1'b1, 1'b0);
    send(32'hB2, 4'b0000, 4'hE, 5'd2, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    check("midreset out_valid", out_valid, 1'b0);
    check("midreset flags_q", flags_q, 4'b0000);
    check("midreset in_ready", in_ready, 1'b1);
    check("midreset out_result", out_result, 0);

    // Randomized run against the queue model
    do_reset();
    model_q.delete();
    model_flags = 4'b0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic acc, pop, p;
      exp_entry_t e;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_result = $urandom;
      in_flags  = 4'($urandom);
      in_cond   = 4'($urandom);
      in_rd     = 5'($urandom);
      in_reg_we = 1'($urandom);
      in_flag_we = 1'($urandom);
      in_branch = 1'($urandom);

      check("rnd in_ready", in_ready, model_q.size() < 2);
      check("rnd out_valid", out_valid, model_q.size() > 0);
      check("rnd flags_q", flags_q, model_flags);
      if (model_q.size() > 0) begin
        check("rnd out_result", out_result, model_q[0].result);
        check("rnd out_rd", out_rd, model_q[0].rd);
        check("rnd out_reg_we", out_reg_we, model_q[0].reg_we);
        check("rnd out_branch", out_branch_taken, model_q[0].branch_taken);
      end

      acc = in_valid && (model_q.size() < 2) && !flush;
      pop = (model_q.size() > 0) && out_ready;
      p   = ref_pass(int'(in_cond), model_flags);
      e.result       = in_result;
      e.rd           = in_rd;
      e.reg_we       = in_reg_we && p;
      e.branch_taken = in_branch && p;
      tick();
      if (flush) begin
        model_q.delete();
      end else begin
        if (pop) void'(model_q.pop_front());
        if (acc) model_q.push_back(e);
      end
      if (acc && p && in_flag_we) model_flags = in_flags;
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the bench always ends on its own.
  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
